// File: rtl/div_pkg.sv
// Shared types for the sequential signed divider.
//   div_state_t   : FSM states of the divider control
//   div_control_t : per-cycle strobes from the control FSM to the datapath
//     load_ops  - capture operands, signs and magnitudes, clear P
//     step      - one restoring shift/subtract iteration
//     correct   - apply sign correction and write Quot/Rem
//     write_dbz - write the divide-by-zero result (Quot=-1, Rem=A)
package div_pkg;

    localparam int DIV_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ESPERAR  = 2'd0,
        CALC     = 2'd1,
        CORREGIR = 2'd2,
        FIN      = 2'd3
    } div_state_t;

    typedef struct packed {
        logic load_ops;
        logic step;
        logic correct;
        logic write_dbz;
    } div_control_t;

endpackage

// File: rtl/div_datapath.sv
// Datapath of the sequential signed divider: operand magnitudes, restoring
// shift/subtract on {P, Qm}, and the final sign correction of Quot/Rem.
// Optional macro DIV_OVF_SAT_EN: on -2^(N-1) / -1 the quotient saturates to
// +2^(N-1)-1 instead of wrapping to -2^(N-1).
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   ctrl          - strobes from the control FSM
//   a, b          - signed dividend / divisor (sampled on load_ops)
//   quot, rem     - registered signed results
//   ovf_case      - the captured operands are the overflow pair
module div_datapath
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  div_control_t ctrl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem,
    output logic         ovf_case
);

    logic [N:0]   p_reg;
    logic [N-1:0] qm_reg;
    logic [N-1:0] mag_b_reg;
    logic         sign_q_reg;
    logic         sign_r_reg;
    logic         ovf_case_reg;
    logic [N-1:0] quot_reg;
    logic [N-1:0] rem_reg;

    logic [N:0]   p_shift;
    logic [N-1:0] qm_shift;
    logic [N:0]   trial;

    // Two's-complement magnitude; -2^(N-1) maps to 2^(N-1) read as unsigned.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
        return v[N-1] ? -v : v;
    endfunction

    // {P, Qm} shifted left by one: the dividend MSB moves into P.
    assign p_shift  = (p_reg << 1) | {{N{1'b0}}, qm_reg[N-1]};
    assign qm_shift = qm_reg << 1;
    // A clear top bit of the trial means P >= |B|, so the subtraction stands.
    assign trial    = p_shift - {1'b0, mag_b_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg        <= '0;
            qm_reg       <= '0;
            mag_b_reg    <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            ovf_case_reg <= 1'b0;
            quot_reg     <= '0;
            rem_reg      <= '0;
        end else begin
            if (ctrl.load_ops) begin
                sign_q_reg   <= a[N-1] ^ b[N-1];
                sign_r_reg   <= a[N-1];
                qm_reg       <= magnitude(a);
                mag_b_reg    <= magnitude(b);
                p_reg        <= '0;
                ovf_case_reg <= (a == {1'b1, {(N-1){1'b0}}}) && (b == {N{1'b1}});
            end
            if (ctrl.write_dbz) begin
                quot_reg <= {N{1'b1}};
                rem_reg  <= a;
            end
            if (ctrl.step) begin
                if (!trial[N]) begin
                    p_reg  <= trial;
                    qm_reg <= {qm_shift[N-1:1], 1'b1};
                end else begin
                    p_reg  <= p_shift;
                    qm_reg <= qm_shift;
                end
            end
            if (ctrl.correct) begin
`ifdef DIV_OVF_SAT_EN
                if (ovf_case_reg) begin
                    quot_reg <= {1'b0, {(N-1){1'b1}}};
                end else begin
                    quot_reg <= sign_q_reg ? -qm_reg : qm_reg;
                end
`else
                // Overflow pair has sign_q=0, so Qm=2^(N-1) wraps to -2^(N-1).
                quot_reg <= sign_q_reg ? -qm_reg : qm_reg;
`endif
                rem_reg  <= sign_r_reg ? -p_reg[N-1:0] : p_reg[N-1:0];
            end
        end
    end

    assign quot     = quot_reg;
    assign rem      = rem_reg;
    assign ovf_case = ovf_case_reg;

endmodule

// File: rtl/division_signed.sv
// Sequential signed divider (restoring, one quotient bit per clock).
// Quot = A / B truncated toward zero, Rem = A - Quot*B with the sign of A.
// Optional macro DIV_OVF_SAT_EN: saturate Quot on -2^(N-1) / -1.
// Ports:
//   clk       - clock
//   rst       - asynchronous active-low reset
//   valid     - start request, sampled only while idle
//   A, B      - signed dividend / divisor
//   Quot, Rem - signed results, held until the next result write
//   busy      - operation in flight (accept edge until leaving FIN)
//   done      - one-cycle result pulse
//   div_zero  - last result was a divide by zero
//   ovf       - last result was -2^(N-1) / -1
module division_signed
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Quot,
    output logic [N-1:0] Rem,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic         ovf
);

    localparam int CW = $clog2(N + 1);

    div_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    div_control_t ctrl;
    logic         div_zero_reg;
    logic         ovf_reg;
    logic         ovf_case;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ESPERAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ctrl       = '0;
        case (state_reg)
            ESPERAR: begin
                if (valid) begin
                    ctrl.load_ops = 1'b1;
                    if (B == '0) begin
                        ctrl.write_dbz = 1'b1;
                        state_next     = FIN;
                    end else begin
                        cnt_next   = CW'(N);
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                ctrl.step = 1'b1;
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = CORREGIR;
                end
            end
            CORREGIR: begin
                ctrl.correct = 1'b1;
                state_next   = FIN;
            end
            FIN: begin
                state_next = ESPERAR;
            end
            default: begin
                state_next = ESPERAR;
            end
        endcase
    end

    // Flags are rewritten together with Quot/Rem, so they always describe
    // the result currently on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else if (ctrl.write_dbz) begin
            div_zero_reg <= 1'b1;
            ovf_reg      <= 1'b0;
        end else if (ctrl.correct) begin
            div_zero_reg <= 1'b0;
            ovf_reg      <= ovf_case;
        end
    end

    div_datapath #(.N(N)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .a        (A),
        .b        (B),
        .quot     (Quot),
        .rem      (Rem),
        .ovf_case (ovf_case)
    );

    assign busy     = (state_reg != ESPERAR);
    assign done     = (state_reg == FIN);
    assign div_zero = div_zero_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_division_signed.sv
// Self-checking bench for division_signed (N=8): directed sign/boundary
// cases, divide by zero, valid ignored while busy, mid-operation reset,
// then randomized operands against an integer-arithmetic reference model.
module tb_division_signed;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Quot;
    logic [7:0] Rem;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    division_signed #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .A        (A),
        .B        (B),
        .Quot     (Quot),
        .Rem      (Rem),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (truncates toward zero, remainder
    // follows the dividend) plus the two special cases.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int ai;
        int bi;
        int qi;
        int ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = 8'hFF; r = a; dz = 1'b1; ov = 1'b0; lat = 0;
        end else if (ai == -128 && bi == -1) begin
`ifdef DIV_OVF_SAT_EN
            q = 8'h7F;
`else
            q = 8'h80;
`endif
            r = 8'h00; dz = 1'b0; ov = 1'b1; lat = 9;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q = qi[7:0]; r = ri[7:0]; dz = 1'b0; ov = 1'b0; lat = 9;
        end
    endtask

    // One transaction. pulse_at >= 0 fires a stray valid with other operands
    // that many edges after acceptance; it must be ignored.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int pulse_at);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         elat;
        int         lat;
        model(a, b, eq, er, edz, eov, elat);
        @(negedge clk);
        A = a; B = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            if (lat == pulse_at) begin
                A = 8'($urandom); B = 8'($urandom_range(1, 255)); valid = 1'b1;
            end
            @(posedge clk); #1;
            valid = 1'b0;
            lat++;
        end
        check("latency", lat, elat);
        check("busy_fin", {31'b0, busy}, 32'd1);
        check("quot", {24'b0, Quot}, {24'b0, eq});
        check("rem", {24'b0, Rem}, {24'b0, er});
        check("div_zero", {31'b0, div_zero}, {31'b0, edz});
        check("ovf", {31'b0, ovf}, {31'b0, eov});
        @(posedge clk); #1;
        check("done_width", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("quot_hold", {24'b0, Quot}, {24'b0, eq});
        $display("op A=%0d B=%0d Quot=%0d Rem=%0d div_zero=%0b ovf=%0b lat=%0d",
                 $signed(a), $signed(b), $signed(Quot), $signed(Rem), div_zero, ovf, lat);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quot"}, {24'b0, Quot}, 32'd0);
        check({tag, "_rem"}, {24'b0, Rem}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_dz"}, {31'b0, div_zero}, 32'd0);
        check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b0; valid = 1'b0; A = '0; B = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        do_op(8'd100, 8'd7, -1);
        do_op(-8'sd100, 8'd7, -1);
        do_op(8'd100, -8'sd7, -1);
        do_op(-8'sd100, -8'sd7, -1);
        do_op(-8'sd5, 8'd0, -1);
        do_op(8'd20, 8'd3, -1);          // clears div_zero
        do_op(8'h80, 8'hFF, -1);         // overflow pair
        do_op(8'h80, 8'd1, -1);
        do_op(8'd7, 8'd100, -1);
        do_op(8'h80, 8'h80, -1);
        do_op(8'd127, 8'h80, -1);
        do_op(8'd100, 8'd7, 3);          // stray valid during CALC

        // Reset four iterations into CALC, checked before any further edge.
        @(negedge clk);
        A = 8'd100; B = 8'd7; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("lost_done", {31'b0, done}, 32'd0);
        check("lost_busy", {31'b0, busy}, 32'd0);
        do_op(8'd127, 8'd2, -1);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i % 10 == 0) ra = 8'h80;
            do_op(ra, rb, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
